// File: rtl/rdn_weight_st.sv
// rdn_weight_st -- RDN weight store / readback engine.
//
// Walks every neuron weight register in bank order A, B, C through the bank
// read ports, packs the weights into LINE_WORDS x 16-bit memory lines and
// writes each line to memory over a req/ack handshake. Every neuron starts a
// new line; unused words of a line are zero.
//
// Optional feature macro: RDN_WST_CHECKSUM_EN
//   defined   : checksum = 16-bit wrapping sum of every captured weight,
//               cleared on go, stable from done until the next go.
//   undefined : checksum tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   go                        start pulse (only honoured in IDLE)
//   a/b/c_rd_data             bank read data, valid the cycle after the strobe
//   read_a/b/c                bank read strobes
//   a/b/c_sel                 neuron index (0 when that bank is not read)
//   a/b/c_weight_sel          weight index (0 when that bank is not read)
//   mem_wr_req/addr/data/ack  line write handshake; data word i at [16*i +: 16]
//   busy                      high outside IDLE/FIN
//   done                      one-cycle pulse after the final line is acked
//   checksum                  see macro note above
module rdn_weight_st #(
   parameter int A_NEURONS  = 15,
   parameter int A_WEIGHTS  = 401,
   parameter int B_NEURONS  = 15,
   parameter int C_NEURONS  = 36,
   parameter int BC_WEIGHTS = 16,
   parameter int LINE_WORDS = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         go,
   input  logic signed [15:0]           a_rd_data,
   input  logic signed [15:0]           b_rd_data,
   input  logic signed [15:0]           c_rd_data,
   output logic                         read_a,
   output logic                         read_b,
   output logic                         read_c,
   output logic [3:0]                   a_sel,
   output logic [3:0]                   b_sel,
   output logic [5:0]                   c_sel,
   output logic [8:0]                   a_weight_sel,
   output logic [3:0]                   b_weight_sel,
   output logic [3:0]                   c_weight_sel,
   output logic                         mem_wr_req,
   output logic [7:0]                   mem_wr_addr,
   output logic [LINE_WORDS*16-1:0]     mem_wr_data,
   input  logic                         mem_wr_ack,
   output logic                         busy,
   output logic                         done,
   output logic [15:0]                  checksum
);

   localparam int IW     = $clog2(LINE_WORDS);
   localparam int A_LPN  = (A_WEIGHTS + LINE_WORDS - 1) / LINE_WORDS;
   localparam int BC_LPN = (BC_WEIGHTS + LINE_WORDS - 1) / LINE_WORDS;
   // Address of the last line of each bank; its ack moves to the next bank.
   localparam logic [7:0] A_LAST = 8'(A_NEURONS * A_LPN - 1);
   localparam logic [7:0] B_LAST = 8'(A_NEURONS * A_LPN + B_NEURONS * BC_LPN - 1);
   localparam logic [7:0] C_LAST = 8'(A_NEURONS * A_LPN + (B_NEURONS + C_NEURONS) * BC_LPN - 1);
   localparam logic [8:0] A_WLAST  = 9'(A_WEIGHTS - 1);
   localparam logic [8:0] BC_WLAST = 9'(BC_WEIGHTS - 1);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, WR, FIN} state_t;

   state_t state_q, state_d, ret_q;

   logic [5:0]                   sel_q;
   logic [8:0]                   wsel_q;
   logic [7:0]                   addr_q;
   logic [LINE_WORDS-1:0][15:0]  buf_q;

   // One-deep read pipeline: the read issued this cycle is captured next cycle.
   logic                         pend_vld_q;
   logic                         pend_last_q;
   logic [IW-1:0]                pend_idx_q;
   logic [1:0]                   pend_bank_q;

   logic                         rd_en;
   logic                         in_rd;
   logic [8:0]                   wlast;
   logic                         neuron_end;
   logic                         line_end;
   logic [1:0]                   bank_code;
   logic [15:0]                  cap_data;

   assign in_rd      = (state_q == RD_A) || (state_q == RD_B) || (state_q == RD_C);
   assign wlast      = (state_q == RD_A) ? A_WLAST : BC_WLAST;
   assign neuron_end = (wsel_q == wlast);
   assign line_end   = neuron_end || (&wsel_q[IW-1:0]);
   assign bank_code  = (state_q == RD_A) ? 2'd0 : (state_q == RD_B) ? 2'd1 : 2'd2;

   always_comb begin
      cap_data = a_rd_data;
      case (pend_bank_q)
         2'd1:    cap_data = b_rd_data;
         2'd2:    cap_data = c_rd_data;
         default: cap_data = a_rd_data;
      endcase
   end

   // Next-state: reads stop in the cycle the last word of a line is captured.
   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      case (state_q)
         IDLE: if (go) state_d = RD_A;
         RD_A, RD_B, RD_C: begin
            if (pend_last_q) state_d = WR;
            else             rd_en   = 1'b1;
         end
         WR: begin
            if (mem_wr_ack) begin
               if      (addr_q == C_LAST) state_d = FIN;
               else if (addr_q == B_LAST) state_d = RD_C;
               else if (addr_q == A_LAST) state_d = RD_B;
               else                       state_d = ret_q;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ret_q       <= IDLE;
         sel_q       <= '0;
         wsel_q      <= '0;
         addr_q      <= '0;
         buf_q       <= '0;
         pend_vld_q  <= 1'b0;
         pend_last_q <= 1'b0;
         pend_idx_q  <= '0;
         pend_bank_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_vld_q  <= rd_en;
         pend_last_q <= rd_en & line_end;
         pend_idx_q  <= wsel_q[IW-1:0];
         pend_bank_q <= bank_code;

         if (rd_en) begin
            if (neuron_end) begin
               wsel_q <= '0;
               sel_q  <= sel_q + 6'd1;
            end else begin
               wsel_q <= wsel_q + 9'd1;
            end
         end

         if (pend_vld_q) buf_q[pend_idx_q] <= cap_data;

         if (in_rd && pend_last_q) ret_q <= state_q;

         if (state_q == IDLE && go) begin
            buf_q  <= '0;
            addr_q <= '0;
            sel_q  <= '0;
            wsel_q <= '0;
         end

         if (state_q == WR && mem_wr_ack) begin
            buf_q <= '0;
            if (addr_q != C_LAST) addr_q <= addr_q + 8'd1;
            // Neuron index restarts when moving to the next bank.
            if (addr_q == A_LAST || addr_q == B_LAST) sel_q <= '0;
         end
      end
   end

`ifdef RDN_WST_CHECKSUM_EN
   logic [15:0] cks_q;
   always_ff @(posedge clk) begin
      if (rst)                        cks_q <= '0;
      else if (state_q == IDLE && go) cks_q <= '0;
      else if (pend_vld_q)            cks_q <= cks_q + cap_data;
   end
   assign checksum = cks_q;
`else
   assign checksum = '0;
`endif

   assign read_a       = rd_en && (state_q == RD_A);
   assign read_b       = rd_en && (state_q == RD_B);
   assign read_c       = rd_en && (state_q == RD_C);
   assign a_sel        = read_a ? sel_q[3:0]  : '0;
   assign b_sel        = read_b ? sel_q[3:0]  : '0;
   assign c_sel        = read_c ? sel_q       : '0;
   assign a_weight_sel = read_a ? wsel_q      : '0;
   assign b_weight_sel = read_b ? wsel_q[3:0] : '0;
   assign c_weight_sel = read_c ? wsel_q[3:0] : '0;

   assign mem_wr_req   = (state_q == WR);
   assign mem_wr_addr  = addr_q;
   assign mem_wr_data  = buf_q;
   assign busy         = (state_q != IDLE) && (state_q != FIN);
   assign done         = (state_q == FIN);

endmodule

// File: tb/tb_rdn_weight_st.sv
module tb_rdn_weight_st;

   localparam int NL      = 246;
   localparam int RUN_CYC = 15 * (12 * 34 + 19) + 51 * 18;

   logic               clk = 1'b0;
   logic               rst;
   logic               go;
   logic signed [15:0] a_rd_data, b_rd_data, c_rd_data;
   logic               read_a, read_b, read_c;
   logic [3:0]         a_sel, b_sel;
   logic [5:0]         c_sel;
   logic [8:0]         a_weight_sel;
   logic [3:0]         b_weight_sel, c_weight_sel;
   logic               mem_wr_req;
   logic [7:0]         mem_wr_addr;
   logic [511:0]       mem_wr_data;
   logic               mem_wr_ack;
   logic               busy, done;
   logic [15:0]        checksum;

   int           n_cmp = 0;
   int           n_bad = 0;
   bit           ones  = 1'b0;
   logic [511:0] model [NL];
   logic [15:0]  exp_sum;

   rdn_weight_st dut (
      .clk(clk), .rst(rst), .go(go),
      .a_rd_data(a_rd_data), .b_rd_data(b_rd_data), .c_rd_data(c_rd_data),
      .read_a(read_a), .read_b(read_b), .read_c(read_c),
      .a_sel(a_sel), .b_sel(b_sel), .c_sel(c_sel),
      .a_weight_sel(a_weight_sel), .b_weight_sel(b_weight_sel), .c_weight_sel(c_weight_sel),
      .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_ack(mem_wr_ack), .busy(busy), .done(done), .checksum(checksum)
   );

   always #5 clk = ~clk;

   // Bank model: registered read port; junk when not strobed so a misaligned
   // capture shows up in the line data.
   always @(posedge clk) begin
      a_rd_data <= read_a ? (ones ? 16'sd1 : {2'd1, 2'b00, a_sel, a_weight_sel[7:0]}) : 16'($urandom);
      b_rd_data <= read_b ? (ones ? 16'sd1 : {2'd2, 2'b00, b_sel, 4'b0000, b_weight_sel}) : 16'($urandom);
      c_rd_data <= read_c ? (ones ? 16'sd1 : {2'd3, c_sel, 4'b0000, c_weight_sel}) : 16'($urandom);
   end

   function automatic logic [15:0] wt(int b, int n, int w, bit o);
      if (o) return 16'd1;
      return {b[1:0], n[5:0], w[7:0]};
   endfunction

   // Expected line images: each neuron's weights chopped into 32-word lines.
   function automatic void build_model(bit o);
      int ln = 0;
      exp_sum = '0;
      for (int b = 1; b <= 3; b++) begin
         int nn = (b == 3) ? 36 : 15;
         int nw = (b == 1) ? 401 : 16;
         for (int n = 0; n < nn; n++) begin
            for (int base = 0; base < nw; base += 32) begin
               logic [511:0] v = '0;
               for (int k = 0; k < 32; k++) begin
                  if (base + k < nw) begin
                     v[16*k +: 16] = wt(b, n, base + k, o);
                     exp_sum       = exp_sum + wt(b, n, base + k, o);
                  end
               end
               model[ln] = v;
               ln++;
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_strobes"}, {read_a, read_b, read_c}, 0);
      chk({tag, "_sels"}, {a_sel, b_sel, c_sel, a_weight_sel, b_weight_sel, c_weight_sel}, 0);
      chk({tag, "_req_addr"}, {mem_wr_req, mem_wr_addr}, 0);
      chk({tag, "_data"}, mem_wr_data, 0);
      chk({tag, "_busy_done_ck"}, {busy, done, checksum}, 0);
   endtask

   // One job: go pulse, then cycle-by-cycle scoreboard of lines against the model.
   task automatic run(input bit o, input bit rnd, input int stall_line, input int go_at,
                      input int rst_addr, input bit chk_cyc);
      int           cyc = 0, busy_cyc = 0, held = 0, dly = 0, exp_addr = 0;
      bit           acked = 1'b0, fin = 1'b0;
      logic [7:0]   h_addr;
      logic [511:0] h_data;
      logic [15:0]  exp_ck;
      ones = o;
      build_model(o);
`ifdef RDN_WST_CHECKSUM_EN
      exp_ck = exp_sum;
`else
      exp_ck = 16'd0;
`endif
      @(negedge clk);
      go = 1'b1;
      while (!fin && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         go = (cyc == go_at);
         if (busy) busy_cyc++;
         if (acked) begin
            chk("req_drop", mem_wr_req, 0);
            if (exp_addr < NL) chk("resume_rd", read_a | read_b | read_c, 1);
            acked = 1'b0;
         end
         if (mem_wr_req) begin
            chk("no_rd_in_wr", {read_a, read_b, read_c}, 0);
            if (held == 0) begin
               chk("line_addr", mem_wr_addr, exp_addr);
               chk("line_data", mem_wr_data, model[exp_addr]);
               h_addr = mem_wr_addr;
               h_data = mem_wr_data;
               dly = (exp_addr == stall_line) ? 7 : (rnd ? int'($urandom_range(3, 0)) : 0);
               if (exp_addr == rst_addr) begin
                  rst = 1'b1;
                  mem_wr_ack = 1'b0;
                  @(negedge clk);
                  rst = 1'b0;
                  chk_idle("mid_rst");
                  return;
               end
            end else begin
               chk("hold_addr", mem_wr_addr, h_addr);
               chk("hold_data", mem_wr_data, h_data);
            end
            mem_wr_ack = (held >= dly);
            if (mem_wr_ack) begin
               held = 0;
               exp_addr++;
               acked = 1'b1;
            end else begin
               held++;
            end
         end else begin
            // Ack while req is low must be ignored.
            mem_wr_ack = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
         end
         if (done) begin
            chk("done_lines", exp_addr, NL);
            chk("busy_at_done", busy, 0);
            chk("checksum", checksum, exp_ck);
            if (chk_cyc) chk("run_cycles", busy_cyc, RUN_CYC);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            mem_wr_ack = 1'b0;
            chk("go_in_fin_ignored", busy, 0);
            chk("done_one_cycle", done, 0);
            chk("checksum_stable", checksum, exp_ck);
            fin = 1'b1;
         end
      end
      go = 1'b0;
      chk("timeout", fin, 1);
   endtask

   initial begin
      rst        = 1'b1;
      go         = 1'b0;
      mem_wr_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      // ack immediate; exact cycle count
      run(1'b0, 1'b0, -1, -1, -1, 1'b1);
      // line 3 stalled 7 cycles; go mid-run ignored
      run(1'b0, 1'b0, 3, 50, -1, 1'b0);
      // random ack delays, reset during WR at addr 100
      run(1'b0, 1'b1, -1, -1, 100, 1'b0);
      // restart from addr 0 after reset, random delays
      run(1'b0, 1'b1, -1, -1, -1, 1'b0);
      // all weights 1: checksum 6831 when enabled, else 0
      run(1'b1, 1'b0, -1, -1, -1, 1'b1);

      repeat (3) @(negedge clk);
      chk("idle_after", {busy, done, mem_wr_req}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
